// File: rtl/bus_sequencer.sv
// Fixed-slot RAM bus sequencer: each 16-cycle frame gives phases 0-7 to the Pi
// bridge and phases 8-15 to the 6502, and produces the one-cycle CPU clock enable.
module bus_sequencer (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic [16:0] pi_addr,
    input  logic [7:0]  pi_data_in,
    input  logic        pi_rw_b,
    input  logic        pi_pending,
    output logic [7:0]  pi_data_out,
    output logic        pi_done,
    input  logic [16:0] cpu_addr,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_rw_b,
    output logic [7:0]  cpu_data_in,
    output logic        cpu_clk_en,
    output logic [16:0] mem_addr,
    output logic [7:0]  mem_data_out,
    input  logic [7:0]  mem_data_in,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic        grant_pi,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PI_ACCESS  = 2'd1,
        PI_DONE    = 2'd2,
        CPU_ACCESS = 2'd3
    } seq_state_t;

    seq_state_t state_q;
    seq_state_t state_d;
    logic [3:0] phase;
    logic [3:0] next_phase;
    logic [2:0] slot_phase;
    logic       armed;
    logic       access_rw_b;
    logic       pi_start;
    logic       pi_slot;
    logic       oe_d;
    logic       we_d;

    assign next_phase = phase + 4'd1;
    assign slot_phase = next_phase[2:0];
    assign pi_start   = (phase == 4'd15) && pi_pending && !pi_done && armed;
    assign state      = state_q;

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes are decoded from the phase about to begin so the registered
    // outputs are stable for the whole phase; both halves share one window.
    always_comb begin
        state_d = state_q;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        pi_slot = (state_q == PI_ACCESS) && !next_phase[3];

        if (phase == 4'd15) begin
            state_d = pi_start ? PI_ACCESS : IDLE;
        end else if (phase == 4'd7) begin
            case (state_q)
                PI_ACCESS: state_d = pi_pending ? PI_DONE : IDLE;
                default:   state_d = CPU_ACCESS;
            endcase
        end

        if (pi_slot || next_phase[3]) begin
            if (access_rw_b) begin
                oe_d = !((slot_phase >= 3'd1) && (slot_phase <= 3'd6));
            end else begin
                we_d = !((slot_phase >= 3'd2) && (slot_phase <= 3'd5));
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            phase        <= 4'd0;
            armed        <= 1'b1;
            access_rw_b  <= 1'b1;
            mem_oe_n     <= 1'b1;
            mem_we_n     <= 1'b1;
            mem_addr     <= 17'd0;
            mem_data_out <= 8'd0;
            pi_data_out  <= 8'd0;
            cpu_data_in  <= 8'd0;
            pi_done      <= 1'b0;
            cpu_clk_en   <= 1'b0;
            grant_pi     <= 1'b0;
        end else begin
            phase      <= next_phase;
            mem_oe_n   <= oe_d;
            mem_we_n   <= we_d;
            grant_pi   <= (state_d == PI_ACCESS);
            cpu_clk_en <= (next_phase == 4'd15);

            // One transfer per pending pulse: re-arm only once pending is seen low.
            if (pi_start) begin
                armed        <= 1'b0;
                mem_addr     <= pi_addr;
                mem_data_out <= pi_data_in;
                access_rw_b  <= pi_rw_b;
            end else if (!pi_pending) begin
                armed <= 1'b1;
            end

            if (phase == 4'd7) begin
                mem_addr     <= cpu_addr;
                mem_data_out <= cpu_data_out;
                access_rw_b  <= cpu_rw_b;
            end

            if ((state_q == PI_ACCESS) && (phase == 4'd6) && access_rw_b) begin
                pi_data_out <= mem_data_in;
            end
            if ((phase == 4'd14) && access_rw_b) begin
                cpu_data_in <= mem_data_in;
            end

            if (!pi_pending) begin
                pi_done <= 1'b0;
            end else if ((state_q == PI_ACCESS) && (phase == 4'd6)) begin
                pi_done <= 1'b1;
            end
        end
    end

endmodule
